// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the multiply/divide unit.
//   - md_op operation codes
//   - FSM state encoding (IDLE, MUL, DIV)
//   - accumulate-mode codes used by the optional multiply-accumulate ops
//   - md_cnt_width(): width of the multiply latency counter
package md_pkg;

   localparam logic [3:0] OP_NONE  = 4'd0;
   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
   localparam logic [3:0] OP_MADD  = 4'd7;
   localparam logic [3:0] OP_MADDU = 4'd8;
   localparam logic [3:0] OP_MSUB  = 4'd9;
   localparam logic [3:0] OP_MSUBU = 4'd10;

   // How the product is combined with {hi,lo} at multiply completion.
   localparam logic [1:0] ACC_NONE = 2'd0;
   localparam logic [1:0] ACC_ADD  = 2'd1;
   localparam logic [1:0] ACC_SUB  = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2
   } md_state_t;

   // Counter must hold values 0..mult_cycles.
   function automatic int md_cnt_width(input int mult_cycles);
      return $clog2(mult_cycles + 1);
   endfunction

endpackage

// File: rtl/md_divider.sv
// md_divider: unsigned iterative restoring divider, one quotient bit per cycle.
//   clk, rst_n          : clock, asynchronous active-low reset
//   load                : start a division; operands are sampled and the first
//                         quotient bit is produced at this same edge
//   dividend, divisor   : WIDTH-bit unsigned operands
//   done                : one-cycle pulse, quotient/remainder valid while high
//   quotient, remainder : registered results
// The load edge performs the first of WIDTH steps, so done is high in the
// (WIDTH)th cycle after load and the parent can commit at the WIDTH-th edge.
module md_divider
   import md_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] rem_r;
   logic [WIDTH-1:0] quo_r;
   logic [WIDTH-1:0] dvs_r;
   logic [CNT_W-1:0] cnt_r;
   logic             done_r;

   logic [WIDTH-1:0] src_rem_s;
   logic [WIDTH-1:0] src_quo_s;
   logic [WIDTH-1:0] src_dvs_s;
   logic [WIDTH:0]   shifted_s;
   logic [WIDTH:0]   diff_s;
   logic [WIDTH-1:0] nxt_rem_s;
   logic [WIDTH-1:0] nxt_quo_s;

   // One restoring step; on load the step starts from fresh operands.
   always_comb begin
      if (load) begin
         src_rem_s = {WIDTH{1'b0}};
         src_quo_s = dividend;
         src_dvs_s = divisor;
      end else begin
         src_rem_s = rem_r;
         src_quo_s = quo_r;
         src_dvs_s = dvs_r;
      end
      shifted_s = {src_rem_s, src_quo_s[WIDTH-1]};
      diff_s    = shifted_s - {1'b0, src_dvs_s};
      // Remainder stays below the divisor, so bit WIDTH of the difference
      // is set exactly when the trial subtraction underflows.
      if (diff_s[WIDTH]) begin
         nxt_rem_s = shifted_s[WIDTH-1:0];
         nxt_quo_s = {src_quo_s[WIDTH-2:0], 1'b0};
      end else begin
         nxt_rem_s = diff_s[WIDTH-1:0];
         nxt_quo_s = {src_quo_s[WIDTH-2:0], 1'b1};
      end
   end

   // Iteration state, step counter and completion pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem_r  <= {WIDTH{1'b0}};
         quo_r  <= {WIDTH{1'b0}};
         dvs_r  <= {WIDTH{1'b0}};
         cnt_r  <= {CNT_W{1'b0}};
         done_r <= 1'b0;
      end else if (load) begin
         rem_r  <= nxt_rem_s;
         quo_r  <= nxt_quo_s;
         dvs_r  <= divisor;
         cnt_r  <= CNT_W'(WIDTH - 1);
         done_r <= 1'b0;
      end else if (cnt_r != {CNT_W{1'b0}}) begin
         rem_r  <= nxt_rem_s;
         quo_r  <= nxt_quo_s;
         cnt_r  <= cnt_r - CNT_W'(1);
         done_r <= (cnt_r == CNT_W'(1));
      end else begin
         done_r <= 1'b0;
      end
   end

   assign done      = done_r;
   assign quotient  = quo_r;
   assign remainder = rem_r;

endmodule

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit owning the HI/LO registers.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request strobe, accepted only while busy=0
//   md_op      : operation code (md_pkg OP_*)
//   a, b       : rs / rt operands
//   busy       : operation in flight (registered)
//   hi, lo     : architectural HI/LO registers
// Optional feature macro MDU_MADD_EN: enables MADD/MADDU/MSUB/MSUBU, which
// add/subtract the product to {hi,lo} as sampled at completion. Without it
// those codes decode as NONE and no accumulate adder exists.
module md_unit
   import md_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [3:0]       md_op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = md_cnt_width(MULT_CYCLES);
   localparam int W2 = 2 * WIDTH;

   function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
      return {WIDTH{1'b0}} - v;
   endfunction

   md_state_t        state_r;
   logic [CW-1:0]    cnt_r;
   logic [W2-1:0]    prod_r;
   logic [WIDTH-1:0] hi_r;
   logic [WIDTH-1:0] lo_r;
   logic             busy_r;
   logic             q_neg_r;
   logic             r_neg_r;
   logic             dz_r;
`ifdef MDU_MADD_EN
   logic [1:0]       acc_r;
   logic [1:0]       op_acc_s;
`endif

   logic             accept_s;
   logic             op_mul_s;
   logic             op_div_s;
   logic             op_signed_s;
   logic             op_mthi_s;
   logic             op_mtlo_s;
   logic [W2-1:0]    a_ext_s;
   logic [W2-1:0]    b_ext_s;
   logic [W2-1:0]    prod_s;
   logic             a_neg_s;
   logic             b_neg_s;
   logic [WIDTH-1:0] mag_a_s;
   logic [WIDTH-1:0] mag_b_s;
   logic             div_load_s;
   logic             div_done_s;
   logic [WIDTH-1:0] div_quo_s;
   logic [WIDTH-1:0] div_rem_s;
   logic [WIDTH-1:0] quo_fix_s;
   logic [WIDTH-1:0] rem_fix_s;
   logic [W2-1:0]    mul_result_s;

   assign accept_s = start & ~busy_r;

   // Operation decode; undefined codes fall through as no-ops.
   always_comb begin
      op_mul_s    = 1'b0;
      op_div_s    = 1'b0;
      op_signed_s = 1'b0;
      op_mthi_s   = 1'b0;
      op_mtlo_s   = 1'b0;
`ifdef MDU_MADD_EN
      op_acc_s    = ACC_NONE;
`endif
      case (md_op)
         OP_MULT:  begin op_mul_s = 1'b1; op_signed_s = 1'b1; end
         OP_MULTU: op_mul_s = 1'b1;
         OP_DIV:   begin op_div_s = 1'b1; op_signed_s = 1'b1; end
         OP_DIVU:  op_div_s = 1'b1;
         OP_MTHI:  op_mthi_s = 1'b1;
         OP_MTLO:  op_mtlo_s = 1'b1;
`ifdef MDU_MADD_EN
         OP_MADD:  begin op_mul_s = 1'b1; op_signed_s = 1'b1; op_acc_s = ACC_ADD; end
         OP_MADDU: begin op_mul_s = 1'b1; op_acc_s = ACC_ADD; end
         OP_MSUB:  begin op_mul_s = 1'b1; op_signed_s = 1'b1; op_acc_s = ACC_SUB; end
         OP_MSUBU: begin op_mul_s = 1'b1; op_acc_s = ACC_SUB; end
`endif
         default:  op_mul_s = 1'b0;
      endcase
   end

   // Extending both operands to 2*WIDTH lets one multiplier serve signed and
   // unsigned ops: the low 2*WIDTH bits of the product are correct for both.
   always_comb begin
      if (op_signed_s) begin
         a_ext_s = {{WIDTH{a[WIDTH-1]}}, a};
         b_ext_s = {{WIDTH{b[WIDTH-1]}}, b};
      end else begin
         a_ext_s = {{WIDTH{1'b0}}, a};
         b_ext_s = {{WIDTH{1'b0}}, b};
      end
      prod_s = a_ext_s * b_ext_s;
   end

   // Signed division runs on magnitudes; signs are reapplied at completion.
   always_comb begin
      a_neg_s    = op_signed_s & a[WIDTH-1];
      b_neg_s    = op_signed_s & b[WIDTH-1];
      mag_a_s    = a_neg_s ? negate(a) : a;
      mag_b_s    = b_neg_s ? negate(b) : b;
      div_load_s = accept_s & op_div_s;
      quo_fix_s  = q_neg_r ? negate(div_quo_s) : div_quo_s;
      rem_fix_s  = r_neg_r ? negate(div_rem_s) : div_rem_s;
   end

   // Value written to {hi,lo} when a multiply completes.
   always_comb begin
`ifdef MDU_MADD_EN
      case (acc_r)
         ACC_ADD: mul_result_s = {hi_r, lo_r} + prod_r;
         ACC_SUB: mul_result_s = {hi_r, lo_r} - prod_r;
         default: mul_result_s = prod_r;
      endcase
`else
      mul_result_s = prod_r;
`endif
   end

   md_divider #(
      .WIDTH (WIDTH)
   ) u_divider (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (div_load_s),
      .dividend  (mag_a_s),
      .divisor   (mag_b_s),
      .done      (div_done_s),
      .quotient  (div_quo_s),
      .remainder (div_rem_s)
   );

   // Control FSM with HI/LO and busy registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         cnt_r   <= {CW{1'b0}};
         prod_r  <= {W2{1'b0}};
         hi_r    <= {WIDTH{1'b0}};
         lo_r    <= {WIDTH{1'b0}};
         busy_r  <= 1'b0;
         q_neg_r <= 1'b0;
         r_neg_r <= 1'b0;
         dz_r    <= 1'b0;
`ifdef MDU_MADD_EN
         acc_r   <= ACC_NONE;
`endif
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (accept_s && op_mul_s) begin
                  prod_r  <= prod_s;
                  cnt_r   <= CW'(MULT_CYCLES);
                  busy_r  <= 1'b1;
                  state_r <= ST_MUL;
`ifdef MDU_MADD_EN
                  acc_r   <= op_acc_s;
`endif
               end else if (accept_s && op_div_s) begin
                  q_neg_r <= a_neg_s ^ b_neg_s;
                  r_neg_r <= a_neg_s;
                  dz_r    <= (b == {WIDTH{1'b0}});
                  busy_r  <= 1'b1;
                  state_r <= ST_DIV;
               end else if (accept_s && op_mthi_s) begin
                  hi_r <= a;
               end else if (accept_s && op_mtlo_s) begin
                  lo_r <= a;
               end
            end
            ST_MUL: begin
               cnt_r <= cnt_r - CW'(1);
               if (cnt_r == CW'(1)) begin
                  {hi_r, lo_r} <= mul_result_s;
                  busy_r       <= 1'b0;
                  state_r      <= ST_IDLE;
               end
            end
            ST_DIV: begin
               if (div_done_s) begin
                  // Divide by zero runs full length but leaves HI/LO intact.
                  if (!dz_r) begin
                     lo_r <= quo_fix_s;
                     hi_r <= rem_fix_s;
                  end
                  busy_r  <= 1'b0;
                  state_r <= ST_IDLE;
               end
            end
            default: begin
               busy_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy = busy_r;
   assign hi   = hi_r;
   assign lo   = lo_r;

endmodule
